enc_binder_scheduler: RTL and testbench
=======================================

Name: enc_binder_scheduler

Overview:
- Sequencing controller for the encoder's binder packs. Each pack holds PACK_SIZE enc_binder instances sharing one start_encoding strobe.
- Takes one sample at a time over a valid/ready handshake. Fires each pack's start in turn, waits out the binder latency, then steers that pack's shifted HVs into the shared bundler with pack_sel/bundle_en.
- Sits between the feature front end and the packs/bundler in the top-level encoder.

Parameters:
- NUM_PACKS, 5, number of binder packs sequenced per sample (>=1)
- BIND_LAT, 1, cycles from a pack's start strobe to its shifted_hv being valid (0..15)
- SEL_W, $clog2(NUM_PACKS) min 1, width of pack_sel

Ports:
- clk  in  1  clock, all logic on rising edge
- nrst  in  1  synchronous reset, active-high (1 = reset)
- sample_valid  in  1  front end has a sample's level HVs ready
- sample_ready  out  1  scheduler can accept a sample
- abort  in  1  synchronous cancel of the current sample
- pack_start  out  NUM_PACKS  one-hot start_encoding strobes, bit p to pack p
- pack_sel  out  SEL_W  index of the pack whose shifted_hv feeds the bundler
- bundle_clear  out  1  1-cycle pulse that clears the bundler accumulator
- bundle_en  out  1  bundler should accumulate the selected pack's output
- bundle_ready  in  1  bundler accepts the current bundle_en beat
- busy  out  1  high in every state except IDLE
- enc_done  out  1  1-cycle pulse when all packs are bundled

Behaviour:
- Moore FSM. All outputs decode from registered state, pack_idx and wait_cnt; no combinational input-to-output paths except none.
- States: IDLE, CLEAR, START, WAIT, ACCUM, DONE.
- Reset values: state=IDLE, pack_idx=0, wait_cnt=0. Outputs: pack_start=0, pack_sel=0, bundle_clear=0, bundle_en=0, busy=0, enc_done=0, sample_ready=0.
  - sample_ready is forced 0 during any cycle with nrst=1 and goes to 1 the first cycle after reset deasserts.
  - Reset mid-operation returns to IDLE on the next edge with no enc_done.
- IDLE: sample_ready=1. On sample_valid=1 -> CLEAR, pack_idx<=0.
- CLEAR: bundle_clear=1 for one cycle -> START.
- START: pack_start[pack_idx]=1 for exactly one cycle, wait_cnt<=BIND_LAT.
  - BIND_LAT=0 -> ACCUM directly.
  - Otherwise -> WAIT.
- WAIT: wait_cnt decrements each cycle. When wait_cnt==1 -> ACCUM, so WAIT lasts BIND_LAT cycles.
- ACCUM: bundle_en=1, pack_sel=pack_idx; held stable while bundle_ready=0.
  - On bundle_ready=1, if pack_idx==NUM_PACKS-1 -> DONE.
  - Otherwise pack_idx++ -> START.
- DONE: enc_done=1 for one cycle -> IDLE. The next sample is accepted one cycle later, never in DONE.
- pack_sel equals pack_idx in all non-IDLE states and 0 in IDLE.
- Timing with handshake at cycle t0 and bundle_ready held 1:
  - bundle_clear at t0+1.
  - pack p start at t0+2+p*(BIND_LAT+2).
  - bundle_en for pack p at t0+2+p*(BIND_LAT+2)+BIND_LAT+1.
  - enc_done at t0+2+NUM_PACKS*(BIND_LAT+2).
  - Defaults give enc_done at t0+17.
- Each stall cycle (ACCUM with bundle_ready=0) delays all later events by one cycle.
- Abort:
  - abort=1 in any non-IDLE state -> IDLE next edge. No enc_done, no further pack_start; pack_idx<=0.
  - abort in IDLE is ignored. If abort and sample_valid are both 1 in IDLE, the sample is accepted.
  - abort has priority over bundle_ready and over the WAIT countdown.
- nrst has priority over everything.
- At most one pack_start bit is high in any cycle, and pack_start and bundle_en are never high together.

Optional Feature:
- Macro: ENC_SCHED_PERF_EN.
- Defined: adds output stall_cnt (16 bits).
  - Cleared to 0 on sample acceptance and on reset.
  - Increments by 1 for each ACCUM cycle with bundle_ready=0; saturates at 16'hFFFF.
  - Holds its value after enc_done or abort until the next acceptance.
- Not defined: port and counter absent; all other behaviour identical.

Test Plan:
- Defaults, bundle_ready=1, one sample at t0 -> bundle_clear at t0+1; pack_start=5'b00001 at t0+2, 5'b00010 at t0+5 ... 5'b10000 at t0+14; bundle_en at t0+4,7,10,13,16 with pack_sel 0..4; enc_done at t0+17; sample_ready=1 again at t0+18.
- BIND_LAT=0, NUM_PACKS=1 -> pack_start at t0+2, bundle_en at t0+3, enc_done at t0+4.
- Hold bundle_ready=0 for 3 cycles at pack 2's ACCUM -> bundle_en and pack_sel=2 stay stable; enc_done at t0+20; with ENC_SCHED_PERF_EN, stall_cnt=3.
- abort at t0+6 (pack 1 WAIT) -> IDLE at t0+7, busy=0, no pack_start[2], no enc_done; a new sample is accepted at t0+7 and restarts at pack 0 with bundle_clear.
- nrst=1 during pack 3 ACCUM -> all outputs 0 next cycle, sample_ready=0 while reset is held, 1 the cycle after release.
- Back-to-back sample_valid held 1 -> second acceptance exactly one cycle after enc_done; never during DONE.

Source files
------------

// File: rtl/enc_binder_scheduler.sv
// enc_binder_scheduler
// Sequencing controller for the encoder's binder packs. It accepts one sample
// over a valid/ready handshake and clears the bundler. For each pack in turn it
// fires that pack's start_encoding strobe, waits BIND_LAT cycles for the
// shifted HVs to settle, then steers the pack into the shared bundler. It
// pulses enc_done once every pack has been bundled.
//
// Ports:
//   clk           clock, all logic on the rising edge
//   nrst          synchronous reset, active-high (1 = reset)
//   sample_valid  front end has a sample's level HVs ready
//   sample_ready  scheduler can accept a sample (IDLE, not in reset)
//   abort         synchronous cancel of the current sample
//   pack_start    one-hot start_encoding strobes, bit p drives pack p
//   pack_sel      index of the pack whose shifted_hv feeds the bundler
//   bundle_clear  1-cycle pulse clearing the bundler accumulator
//   bundle_en     bundler accumulates the selected pack's output
//   bundle_ready  bundler accepts the current bundle_en beat
//   busy          high in every state except IDLE
//   enc_done      1-cycle pulse when all packs are bundled
//   stall_cnt     (ENC_SCHED_PERF_EN only) saturating count of ACCUM cycles
//                 spent waiting on bundle_ready since the last acceptance
//
// Optional feature macro: ENC_SCHED_PERF_EN
//
// All outputs are registers loaded from the next-state decode. This keeps
// them glitch-free and free of input-to-output paths. It also holds
// sample_ready low for every cycle that follows a reset edge.

module enc_binder_scheduler #(
    parameter int NUM_PACKS = 5,
    parameter int BIND_LAT  = 1,
    parameter int SEL_W     = (NUM_PACKS > 1) ? $clog2(NUM_PACKS) : 1
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 sample_valid,
    output logic                 sample_ready,
    input  logic                 abort,
    output logic [NUM_PACKS-1:0] pack_start,
    output logic [SEL_W-1:0]     pack_sel,
    output logic                 bundle_clear,
    output logic                 bundle_en,
    input  logic                 bundle_ready,
    output logic                 busy,
    output logic                 enc_done
`ifdef ENC_SCHED_PERF_EN
    ,
    output logic [15:0]          stall_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_START,
        S_WAIT,
        S_ACCUM,
        S_DONE
    } state_t;

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_PACKS - 1);
    localparam logic [3:0]       LAT      = 4'(BIND_LAT);

    state_t           state, state_d;
    logic [SEL_W-1:0] pack_idx, pack_idx_d;
    logic [3:0]       wait_cnt, wait_cnt_d;

    // Next-state logic. Abort outranks every transition except in IDLE.
    always_comb begin
        state_d    = state;
        pack_idx_d = pack_idx;
        wait_cnt_d = wait_cnt;
        if (abort && (state != S_IDLE)) begin
            state_d    = S_IDLE;
            pack_idx_d = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (sample_valid) begin
                        state_d    = S_CLEAR;
                        pack_idx_d = '0;
                    end
                end
                S_CLEAR: state_d = S_START;
                S_START: begin
                    wait_cnt_d = LAT;
                    state_d    = (BIND_LAT == 0) ? S_ACCUM : S_WAIT;
                end
                S_WAIT: begin
                    // Loaded with BIND_LAT in START, so WAIT spans BIND_LAT cycles.
                    wait_cnt_d = wait_cnt - 4'd1;
                    if (wait_cnt <= 4'd1) begin
                        state_d = S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (bundle_ready) begin
                        if (pack_idx == LAST_IDX) begin
                            state_d = S_DONE;
                        end else begin
                            pack_idx_d = pack_idx + SEL_W'(1);
                            state_d    = S_START;
                        end
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and registered Moore outputs
    always_ff @(posedge clk) begin
        if (nrst) begin
            state        <= S_IDLE;
            pack_idx     <= '0;
            wait_cnt     <= '0;
            sample_ready <= 1'b0;
            pack_start   <= '0;
            pack_sel     <= '0;
            bundle_clear <= 1'b0;
            bundle_en    <= 1'b0;
            busy         <= 1'b0;
            enc_done     <= 1'b0;
        end else begin
            state        <= state_d;
            pack_idx     <= pack_idx_d;
            wait_cnt     <= wait_cnt_d;
            sample_ready <= (state_d == S_IDLE);
            pack_start   <= (state_d == S_START) ? (NUM_PACKS'(1) << pack_idx_d) : '0;
            pack_sel     <= (state_d == S_IDLE) ? '0 : pack_idx_d;
            bundle_clear <= (state_d == S_CLEAR);
            bundle_en    <= (state_d == S_ACCUM);
            busy         <= (state_d != S_IDLE);
            enc_done     <= (state_d == S_DONE);
        end
    end

`ifdef ENC_SCHED_PERF_EN
    // Bundler back-pressure counter: restarts on acceptance, sticky afterwards.
    always_ff @(posedge clk) begin
        if (nrst) begin
            stall_cnt <= '0;
        end else if ((state == S_IDLE) && sample_valid) begin
            stall_cnt <= '0;
        end else if ((state == S_ACCUM) && !bundle_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_enc_binder_scheduler.sv
// Testbench for enc_binder_scheduler: default-parameter DUT checked through
// an event scoreboard, plus a NUM_PACKS=1 / BIND_LAT=0 instance.
module tb_enc_binder_scheduler;

    localparam int NP  = 5;
    localparam int LAT = 1;
    localparam int PER = LAT + 2;
    localparam int NEVER = 1 << 30;

    logic          clk = 1'b0;
    logic          nrst = 1'b1;
    logic          sample_valid = 1'b0;
    logic          abort = 1'b0;
    logic          bundle_ready = 1'b1;
    logic          sample_ready;
    logic [NP-1:0] pack_start;
    logic [2:0]    pack_sel;
    logic          bundle_clear, bundle_en, busy, enc_done;

    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [0:0]    s_start;
    logic [0:0]    s_sel;
    logic          s_clear, s_en, s_busy, s_done;
`ifdef ENC_SCHED_PERF_EN
    logic [15:0]   stall_cnt;
    logic [15:0]   s_stall_cnt;
`endif

    enc_binder_scheduler #(.NUM_PACKS(NP), .BIND_LAT(LAT)) u_dut (
        .clk(clk), .nrst(nrst), .sample_valid(sample_valid), .sample_ready(sample_ready),
        .abort(abort), .pack_start(pack_start), .pack_sel(pack_sel),
        .bundle_clear(bundle_clear), .bundle_en(bundle_en), .bundle_ready(bundle_ready),
        .busy(busy), .enc_done(enc_done)
`ifdef ENC_SCHED_PERF_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    enc_binder_scheduler #(.NUM_PACKS(1), .BIND_LAT(0)) u_small (
        .clk(clk), .nrst(nrst), .sample_valid(s_valid), .sample_ready(s_ready),
        .abort(1'b0), .pack_start(s_start), .pack_sel(s_sel),
        .bundle_clear(s_clear), .bundle_en(s_en), .bundle_ready(1'b1),
        .busy(s_busy), .enc_done(s_done)
`ifdef ENC_SCHED_PERF_EN
        , .stall_cnt(s_stall_cnt)
`endif
    );

    typedef struct {
        int cyc;
        int kind;   // 0 clear, 1 start, 2 bundle_en, 3 done
        int val;
    } evt_t;

    evt_t exp_q[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic push(input int c, input int k, input int v, input int cutoff);
        evt_t e;
        if (c < cutoff) begin
            e.cyc = c; e.kind = k; e.val = v;
            exp_q.push_back(e);
        end
    endtask

    // Expected events from the documented timing; ns stall cycles at pack sp.
    task automatic push_sample(input int t0, input int sp, input int ns, input int cutoff);
        int st, d, len;
        push(t0 + 1, 0, 0, cutoff);
        for (int p = 0; p < NP; p++) begin
            d   = (p > sp) ? ns : 0;
            st  = t0 + 2 + p * PER + d;
            len = 1 + ((p == sp) ? ns : 0);
            push(st, 1, 1 << p, cutoff);
            for (int k = 0; k < len; k++) push(st + LAT + 1 + k, 2, p, cutoff);
        end
        push(t0 + 2 + NP * PER + ns, 3, 0, cutoff);
    endtask

    task automatic take(input int k, input int v);
        evt_t e;
        if (exp_q.size() == 0) begin
            check("unexpected_evt", k, 32'hFF);
        end else begin
            e = exp_q.pop_front();
            check("evt_kind", k, e.kind);
            check("evt_cyc", cyc, e.cyc);
            check("evt_val", v, e.val);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check("start_onehot", 32'($countones(pack_start) <= 1), 1);
            check("start_en_excl", 32'((|pack_start) && bundle_en), 0);
            if (bundle_clear) take(0, 0);
            if (|pack_start)  take(1, int'(pack_start));
            if (bundle_en)    take(2, int'(pack_sel));
            if (enc_done)     take(3, 0);
        end
    end

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Handshake one sample at the current or a later negedge; returns t0.
    task automatic accept(input bit with_abort, output int t0);
        int guard = 0;
        while (!sample_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("ready_timeout", 32'(guard < 100), 1);
        sample_valid = 1'b1;
        abort = with_abort;
        t0 = cyc;
        @(negedge clk);
        sample_valid = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, b;
        repeat (3) @(negedge clk);
        check("rst_ready", sample_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_start", pack_start, 0);
        check("rst_sel", pack_sel, 0);
        check("rst_clear", bundle_clear, 0);
        check("rst_en", bundle_en, 0);
        check("rst_done", enc_done, 0);
        nrst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", sample_ready, 1);
        check("small_ready_after_rst", s_ready, 1);
        mon_en = 1'b1;

        // Clean sample, bundle_ready held high
        accept(1'b0, t0);
        push_sample(t0, -1, 0, NEVER);
        wait_cyc(t0 + 17);
        check("busy_in_done", busy, 1);
        check("ready_in_done", sample_ready, 0);
        wait_cyc(t0 + 18);
        check("ready_again", sample_ready, 1);
        check("idle_busy", busy, 0);
        check("q_empty_clean", exp_q.size(), 0);

        // Single pack, zero latency
        s_valid = 1'b1;
        t1 = cyc;
        @(negedge clk);
        s_valid = 1'b0;
        check("small_clear", s_clear, 1);
        @(negedge clk);
        check("small_start", s_start, 1);
        check("small_en_off", s_en, 0);
        @(negedge clk);
        check("small_en", s_en, 1);
        check("small_sel", s_sel, 0);
        check("small_start_off", s_start, 0);
        @(negedge clk);
        check("small_done", s_done, 1);
        check("small_cyc", cyc - t1, 4);
        @(negedge clk);
        check("small_ready", s_ready, 1);
        check("small_busy", s_busy, 0);
`ifdef ENC_SCHED_PERF_EN
        check("small_stall_cnt", s_stall_cnt, 0);
`endif

        // Three stall cycles at pack 2's ACCUM
        accept(1'b0, t0);
        push_sample(t0, 2, 3, NEVER);
        wait_cyc(t0 + 10);
        bundle_ready = 1'b0;
        wait_cyc(t0 + 13);
        bundle_ready = 1'b1;
        wait_cyc(t0 + 21);
        check("stall_ready", sample_ready, 1);
        check("q_empty_stall", exp_q.size(), 0);
`ifdef ENC_SCHED_PERF_EN
        check("stall_cnt", stall_cnt, 3);
`endif

        // Abort in pack 1's WAIT, then restart with abort+valid in IDLE
        accept(1'b0, t0);
        push_sample(t0, -1, 0, t0 + 6);
        wait_cyc(t0 + 6);
        abort = 1'b1;
        wait_cyc(t0 + 7);
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_ready", sample_ready, 1);
        check("abort_start", pack_start, 0);
        check("abort_done", enc_done, 0);
        check("q_empty_abort", exp_q.size(), 0);
        accept(1'b1, t1);
        check("abort_restart_cyc", t1 - t0, 7);
        push_sample(t1, -1, 0, NEVER);
        wait_cyc(t1 + 18);
        check("q_empty_restart", exp_q.size(), 0);

        // Reset during pack 3's ACCUM
        accept(1'b0, t0);
        push_sample(t0, -1, 0, t0 + 14);
        wait_cyc(t0 + 13);
        nrst = 1'b1;
        wait_cyc(t0 + 14);
        check("mrst_start", pack_start, 0);
        check("mrst_en", bundle_en, 0);
        check("mrst_sel", pack_sel, 0);
        check("mrst_busy", busy, 0);
        check("mrst_done", enc_done, 0);
        check("mrst_ready", sample_ready, 0);
        wait_cyc(t0 + 15);
        nrst = 1'b0;
        check("mrst_ready_held", sample_ready, 0);
        wait_cyc(t0 + 16);
        check("mrst_ready_rel", sample_ready, 1);
        check("q_empty_rst", exp_q.size(), 0);

        // Back-to-back with sample_valid held high
        sample_valid = 1'b1;
        b = -1;
        t0 = cyc;
        for (int i = 0; i < 100 && !sample_ready; i++) @(negedge clk);
        t0 = cyc;
        push_sample(t0, -1, 0, NEVER);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (enc_done) check("b2b_ready_in_done", sample_ready, 0);
            if (sample_ready) begin
                b = cyc;
                break;
            end
        end
        check("b2b_gap", b - t0, 18);
        if (b >= 0) push_sample(b, -1, 0, NEVER);
        @(negedge clk);
        sample_valid = 1'b0;
        wait_cyc(t0 + 40);
        check("q_empty_b2b", exp_q.size(), 0);

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
